// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        ROT_R  = 2'b00,
        ROT_L  = 2'b01,
        BOUNCE = 2'b10,
        LFSR   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] LED_RESET_VAL = 8'h01;
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam int unsigned PRESC_W      = 27;

    // Taps 7,5,4,3 of the current pattern.
    function automatic logic lfsr_fb(input logic [7:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-sample debounce counter and a one-cycle
// pulse on each accepted rising edge of the button level.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: tick prescaler, debounced mode/speed buttons and mode FSM.
// Define LED_PATTERN_LFSR_EN to include the LFSR pattern mode.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       run,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       tick
);

    logic               mode_press, speed_press, any_press;
    logic               tick_raw, tick_int;
    logic [PRESC_W-1:0] presc_q, presc_d, limit;
    logic [1:0]         speed_q, speed_d;
    logic [7:0]         led_q, led_d;
    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_speed),
        .press (speed_press)
    );

    assign any_press = mode_press | speed_press;
    assign limit     = PRESC_W'(TICK_DIV) >> speed_q;
    assign tick_raw  = run & (presc_q == (limit - PRESC_W'(1)));
    // A press restarts the period, so a coincident tick is dropped.
    assign tick_int  = tick_raw & ~any_press;

    always_comb begin
        presc_d = presc_q;
        if (any_press) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = tick_raw ? '0 : presc_q + PRESC_W'(1);
        end
    end

    assign speed_d = speed_q + {1'b0, speed_press};

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            ROT_R:  if (mode_press) mode_d = ROT_L;
            ROT_L:  if (mode_press) mode_d = BOUNCE;
`ifdef LED_PATTERN_LFSR_EN
            BOUNCE: if (mode_press) mode_d = LFSR;
            LFSR:   if (mode_press) mode_d = ROT_R;
`else
            BOUNCE: if (mode_press) mode_d = ROT_R;
`endif
            default: mode_d = ROT_R;
        endcase
    end

    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        if (mode_press) begin
            led_d = LED_RESET_VAL;
            dir_d = DIR_LEFT;
        end else if (tick_int) begin
            if (led_q == 8'h00) begin
                led_d = LED_RESET_VAL;
            end else begin
                case (mode_q)
                    ROT_R: led_d = {led_q[0], led_q[7:1]};
                    ROT_L: led_d = {led_q[6:0], led_q[7]};
                    BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            if (led_q[7]) begin
                                dir_d = DIR_RIGHT;
                                led_d = {1'b0, led_q[7:1]};
                            end else begin
                                led_d = {led_q[6:0], 1'b0};
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_d = DIR_LEFT;
                                led_d = {led_q[6:0], 1'b0};
                            end else begin
                                led_d = {1'b0, led_q[7:1]};
                            end
                        end
                    end
`ifdef LED_PATTERN_LFSR_EN
                    LFSR: led_d = {led_q[6:0], lfsr_fb(led_q)};
`else
`endif
                    default: led_d = LED_RESET_VAL;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            speed_q <= 2'd0;
            mode_q  <= ROT_R;
            dir_q   <= DIR_LEFT;
            led_q   <= LED_RESET_VAL;
        end else begin
            presc_q <= presc_d;
            speed_q <= speed_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign speed = speed_q;
    assign tick  = tick_int;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with a short prescaler and debounce window.
module tb_led_pattern_ctrl;

    localparam int unsigned TICK_DIV = 8;
    localparam int unsigned DEB      = 4;

    typedef struct packed {
        logic [7:0] led;
        logic [1:0] mode;
        logic [1:0] speed;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, btn_mode, btn_speed, run;
    logic [7:0] led;
    logic [1:0] mode, speed;
    logic       tick;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_speed (btn_speed),
        .run       (run),
        .led       (led),
        .mode      (mode),
        .speed     (speed),
        .tick      (tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic [1:0] m, input logic [1:0] s);
        exp_t e;
        e.led   = l;
        e.mode  = m;
        e.speed = s;
        sb_q.push_back(e);
    endtask

    // Monitor: a tick pops the expected post-tick state, compared one cycle later.
    initial begin
        exp_t cur;
        bit   pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    check("sb_led", led, cur.led);
                    check("sb_mode", mode, cur.mode);
                    check("sb_speed", speed, cur.speed);
                    pending = 1'b0;
                end
                if (tick === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check("tick_expected", sb_q.size(), 1);
                    end else begin
                        cur     = sb_q.pop_front();
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    // Runs until n ticks are seen; reports cycles to the first tick and the last period.
    task automatic run_ticks(input int n, output int first, output int gap);
        int cyc, k, prev;
        cyc = 0; k = 0; prev = 0; first = 0; gap = 0;
        run = 1'b1;
        while (k < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (tick === 1'b1) begin
                k++;
                if (k == 1) first = cyc;
                else gap = cyc - prev;
                prev = cyc;
            end
        end
        check("tick_count", k, n);
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic press_btn(input bit is_mode, input int hold);
        if (is_mode) btn_mode = 1'b1;
        else btn_speed = 1'b1;
        repeat (hold) @(posedge clk);
        #1 btn_mode = 1'b0;
        btn_speed = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, gap;
        logic [7:0] bounce_seq [15];
        bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        reset = 1'b0; run = 1'b0; btn_mode = 1'b0; btn_speed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", led, 8'h01);
        check("rst_mode", mode, 2'd0);
        check("rst_speed", speed, 2'd0);
        check("rst_tick", tick, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Idle rotate-right at speed 0
        push(8'h80, 2'd0, 2'd0); push(8'h40, 2'd0, 2'd0); push(8'h20, 2'd0, 2'd0);
        run_ticks(3, first, gap);
        check("first_tick_s0", first, 8);
        check("period_s0", gap, 8);

        // Speed presses
        press_btn(1'b0, 6);
        check("speed_1", speed, 2'd1);
        push(8'h10, 2'd0, 2'd1); push(8'h08, 2'd0, 2'd1);
        run_ticks(2, first, gap);
        check("first_tick_s1", first, 4);
        check("period_s1", gap, 4);
        press_btn(1'b0, 6);
        check("speed_2", speed, 2'd2);
        press_btn(1'b0, 6);
        check("speed_3", speed, 2'd3);
        push(8'h04, 2'd0, 2'd3); push(8'h02, 2'd0, 2'd3);
        run_ticks(2, first, gap);
        check("first_tick_s3", first, 1);
        check("period_s3", gap, 1);
        press_btn(1'b0, 6);
        check("speed_wrap", speed, 2'd0);
        press_btn(1'b0, 2);
        check("glitch_ignored", speed, 2'd0);
        push(8'h01, 2'd0, 2'd0); push(8'h80, 2'd0, 2'd0);
        run_ticks(2, first, gap);
        check("period_s0_again", gap, 8);

        // Mode presses into bounce
        press_btn(1'b1, 6);
        check("mode_1", mode, 2'd1);
        check("mode_1_led", led, 8'h01);
        press_btn(1'b1, 6);
        check("mode_2", mode, 2'd2);
        check("mode_2_led", led, 8'h01);
        foreach (bounce_seq[i]) push(bounce_seq[i], 2'd2, 2'd0);
        run_ticks(15, first, gap);
        check("period_bounce", gap, 8);

        press_btn(1'b1, 6);
`ifdef LED_PATTERN_LFSR_EN
        check("mode_3", mode, 2'd3);
        check("mode_3_led", led, 8'h01);
        push(8'h02, 2'd3, 2'd0); push(8'h04, 2'd3, 2'd0); push(8'h08, 2'd3, 2'd0);
        push(8'h11, 2'd3, 2'd0); push(8'h23, 2'd3, 2'd0);
        run_ticks(5, first, gap);
        press_btn(1'b1, 6);
        check("mode_wrap", mode, 2'd0);
        check("mode_wrap_led", led, 8'h01);
`else
        check("mode_wrap", mode, 2'd0);
        check("mode_wrap_led", led, 8'h01);
`endif

        // Freeze mid-count with run=0, then resume from the held count
        push(8'h80, 2'd0, 2'd0);
        run_ticks(1, first, gap);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        first = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick === 1'b1) first++;
        end
        check("freeze_no_tick", first, 0);
        check("freeze_led", led, 8'h80);
        @(posedge clk);
        #1;
        push(8'h40, 2'd0, 2'd0);
        run_ticks(1, first, gap);
        check("resume_latency", first, 5);

        // Mode press landing exactly on a would-be tick
        push(8'h20, 2'd0, 2'd0);
        run = 1'b1;
        repeat (9) @(posedge clk);
        #1 btn_mode = 1'b1;
        repeat (6) @(posedge clk);
        #1 btn_mode = 1'b0;
        @(negedge clk);
        check("press_drops_tick", tick, 1'b0);
        @(negedge clk);
        check("press_tick_mode", mode, 2'd1);
        check("press_tick_led", led, 8'h01);
        push(8'h02, 2'd1, 2'd0);
        run_ticks(1, first, gap);

        // Asynchronous reset mid-count
        run = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_led", led, 8'h01);
        check("async_rst_mode", mode, 2'd0);
        check("async_rst_speed", speed, 2'd0);
        check("async_rst_tick", tick, 1'b0);
        @(posedge clk);
        #1 run = 1'b0;
        reset = 1'b1;
        push(8'h80, 2'd0, 2'd0);
        run_ticks(1, first, gap);
        check("post_rst_first_tick", first, 8);

        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
